// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE/EXE/MEM/WB/HALT sequencer
// that produces the datapath strobes and mux selects for each instruction.
module mc_ctrl #(
    parameter int TRAP_ON_ILLEGAL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       pc_wr,
    output logic [1:0] npc_sel,
    output logic       ir_wr,
    output logic       reg_wr,
    output logic [1:0] reg_dst,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic       ext_op,
    output logic       mem_wr,
    output logic [1:0] mem_to_reg,
    output logic [2:0] state,
    output logic       instr_done
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam bit TRAP = (TRAP_ON_ILLEGAL != 0);

    state_t cur, nxt;

    logic r_type, is_addu, is_subu, is_jr, is_ori, is_lui;
    logic is_lw, is_sw, is_beq, is_j, is_jal, legal;

    assign r_type  = (op == 6'h00);
    assign is_addu = r_type && (func == 6'h21);
    assign is_subu = r_type && (func == 6'h23);
    assign is_jr   = r_type && (func == 6'h08);
    assign is_ori  = (op == 6'h0D);
    assign is_lui  = (op == 6'h0F);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_j    = (op == 6'h02);
    assign is_jal  = (op == 6'h03);
    assign legal   = is_addu | is_subu | is_jr | is_ori | is_lui |
                     is_lw | is_sw | is_beq | is_j | is_jal;

    // ALU selects depend only on the held opcode, so they stay stable from EXE through MEM/WB
    logic       sel_src, sel_ext;
    logic [2:0] sel_aop;

    always_comb begin
        sel_src = 1'b0;
        sel_aop = 3'd0;
        sel_ext = 1'b0;
        if (is_subu || is_beq) sel_aop = 3'd1;
        if (is_ori) begin
            sel_src = 1'b1;
            sel_aop = 3'd2;
        end
        if (is_lui) begin
            sel_src = 1'b1;
            sel_aop = 3'd3;
        end
        if (is_lw || is_sw) begin
            sel_src = 1'b1;
            sel_ext = 1'b1;
        end
    end

    logic       pc_wr_c, ir_wr_c, reg_wr_c, alu_src_c, ext_op_c, mem_wr_c;
    logic [1:0] npc_sel_c, reg_dst_c, mem_to_reg_c;
    logic [2:0] alu_op_c;

    always_comb begin
        nxt          = FETCH;
        pc_wr_c      = 1'b0;
        npc_sel_c    = 2'd0;
        ir_wr_c      = 1'b0;
        reg_wr_c     = 1'b0;
        reg_dst_c    = 2'd0;
        alu_src_c    = 1'b0;
        alu_op_c     = 3'd0;
        ext_op_c     = 1'b0;
        mem_wr_c     = 1'b0;
        mem_to_reg_c = 2'd0;
        case (cur)
            FETCH: begin
                ir_wr_c = 1'b1;
                pc_wr_c = 1'b1;
                nxt     = DECODE;
            end
            DECODE: begin
                if (is_j || is_jal) begin
                    pc_wr_c   = 1'b1;
                    npc_sel_c = 2'd2;
                    if (is_jal) begin
                        reg_wr_c     = 1'b1;
                        reg_dst_c    = 2'd2;
                        mem_to_reg_c = 2'd2;
                    end
                end else if (is_jr) begin
                    pc_wr_c   = 1'b1;
                    npc_sel_c = 2'd3;
                end else if (!legal) begin
                    nxt = TRAP ? HALT : FETCH;
                end else begin
                    nxt = EXE;
                end
            end
            EXE: begin
                alu_src_c = sel_src;
                alu_op_c  = sel_aop;
                ext_op_c  = sel_ext;
                if (is_beq) begin
                    pc_wr_c   = zero;
                    npc_sel_c = 2'd1;
                end else if (is_lw || is_sw) begin
                    nxt = MEM;
                end else if (is_addu || is_subu || is_ori || is_lui) begin
                    nxt = WB;
                end
            end
            MEM: begin
                alu_src_c = sel_src;
                alu_op_c  = sel_aop;
                ext_op_c  = sel_ext;
                if (is_sw) mem_wr_c = 1'b1;
                else if (is_lw) nxt = WB;
            end
            WB: begin
                alu_src_c    = sel_src;
                alu_op_c     = sel_aop;
                ext_op_c     = sel_ext;
                reg_wr_c     = 1'b1;
                reg_dst_c    = r_type ? 2'd1 : 2'd0;
                mem_to_reg_c = is_lw ? 2'd1 : 2'd0;
            end
            HALT: nxt = HALT;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) cur <= FETCH;
        else       cur <= nxt;
    end

    // Reset forces every output low in the same cycle, even mid-instruction or in HALT
    assign pc_wr      = pc_wr_c & ~reset;
    assign npc_sel    = reset ? 2'd0 : npc_sel_c;
    assign ir_wr      = ir_wr_c & ~reset;
    assign reg_wr     = reg_wr_c & ~reset;
    assign reg_dst    = reset ? 2'd0 : reg_dst_c;
    assign alu_src    = alu_src_c & ~reset;
    assign alu_op     = reset ? 3'd0 : alu_op_c;
    assign ext_op     = ext_op_c & ~reset;
    assign mem_wr     = mem_wr_c & ~reset;
    assign mem_to_reg = reset ? 2'd0 : mem_to_reg_c;
    assign state      = reset ? 3'd0 : cur;
    assign instr_done = ~reset && (nxt == FETCH) && (cur != FETCH);

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed and random instructions compared cycle by
// cycle against a per-instruction table of expected control vectors.
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset0 = 1'b1;
    logic       reset1 = 1'b1;
    logic [5:0] op = 6'd0;
    logic [5:0] func = 6'd0;
    logic       zero = 1'b0;

    logic       pc_wr0, ir_wr0, reg_wr0, alu_src0, ext_op0, mem_wr0, done0;
    logic [1:0] npc_sel0, reg_dst0, m2r0;
    logic [2:0] alu_op0, state0;
    logic       pc_wr1, ir_wr1, reg_wr1, alu_src1, ext_op1, mem_wr1, done1;
    logic [1:0] npc_sel1, reg_dst1, m2r1;
    logic [2:0] alu_op1, state1;

    always #5 clk = ~clk;

    mc_ctrl #(.TRAP_ON_ILLEGAL(0)) dut_nop (
        .clk(clk), .reset(reset0), .op(op), .func(func), .zero(zero),
        .pc_wr(pc_wr0), .npc_sel(npc_sel0), .ir_wr(ir_wr0), .reg_wr(reg_wr0),
        .reg_dst(reg_dst0), .alu_src(alu_src0), .alu_op(alu_op0), .ext_op(ext_op0),
        .mem_wr(mem_wr0), .mem_to_reg(m2r0), .state(state0), .instr_done(done0)
    );

    mc_ctrl #(.TRAP_ON_ILLEGAL(1)) dut_trap (
        .clk(clk), .reset(reset1), .op(op), .func(func), .zero(zero),
        .pc_wr(pc_wr1), .npc_sel(npc_sel1), .ir_wr(ir_wr1), .reg_wr(reg_wr1),
        .reg_dst(reg_dst1), .alu_src(alu_src1), .alu_op(alu_op1), .ext_op(ext_op1),
        .mem_wr(mem_wr1), .mem_to_reg(m2r1), .state(state1), .instr_done(done1)
    );

    logic [18:0] obs0, obs1;
    assign obs0 = {state0, pc_wr0, npc_sel0, ir_wr0, reg_wr0, reg_dst0, alu_src0,
                   alu_op0, ext_op0, mem_wr0, m2r0, done0};
    assign obs1 = {state1, pc_wr1, npc_sel1, ir_wr1, reg_wr1, reg_dst1, alu_src1,
                   alu_op1, ext_op1, mem_wr1, m2r1, done1};

    typedef enum {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL} kind_t;

    logic [5:0] op_tab   [0:9] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    logic [5:0] func_tab [0:9] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    int errors = 0;
    int checks = 0;
    logic [18:0] exp_q[$];

    function automatic logic [18:0] mk(int s, int pw, int npc, int irw, int rw, int rd,
                                       int src, int aop, int ext, int mw, int m2r, int dn);
        return {3'(s), 1'(pw), 2'(npc), 1'(irw), 1'(rw), 2'(rd), 1'(src),
                3'(aop), 1'(ext), 1'(mw), 2'(m2r), 1'(dn)};
    endfunction

    function automatic kind_t kind_of(logic [5:0] o, logic [5:0] f);
        case (o)
            6'h00: case (f)
                       6'h21: return K_ADDU;
                       6'h23: return K_SUBU;
                       6'h08: return K_JR;
                       default: return K_ILL;
                   endcase
            6'h0D: return K_ORI;
            6'h0F: return K_LUI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    // Reference: the whole per-cycle output trace of one instruction, from FETCH to its last cycle
    task automatic build_expect(input kind_t k, input logic z, input bit trap);
        int src, aop, ext;
        bit mem_path, has_wb;
        exp_q.delete();
        exp_q.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        case (k)
            K_J:   exp_q.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            K_JAL: exp_q.push_back(mk(1, 1, 2, 0, 1, 2, 0, 0, 0, 0, 2, 1));
            K_JR:  exp_q.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            K_ILL: begin
                if (trap) begin
                    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                    for (int i = 0; i < 10; i++) exp_q.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                end else begin
                    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
                end
            end
            default: begin
                src = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW) ? 1 : 0;
                aop = (k == K_SUBU || k == K_BEQ) ? 1 : (k == K_ORI) ? 2 : (k == K_LUI) ? 3 : 0;
                ext = (k == K_LW || k == K_SW) ? 1 : 0;
                mem_path = (k == K_LW || k == K_SW);
                has_wb = !(k == K_SW || k == K_BEQ);
                exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                if (k == K_BEQ) exp_q.push_back(mk(2, int'(z), 1, 0, 0, 0, src, aop, ext, 0, 0, 1));
                else            exp_q.push_back(mk(2, 0, 0, 0, 0, 0, src, aop, ext, 0, 0, 0));
                if (mem_path)
                    exp_q.push_back(mk(3, 0, 0, 0, 0, 0, src, aop, ext, int'(k == K_SW), 0, int'(k == K_SW)));
                if (has_wb)
                    exp_q.push_back(mk(4, 0, 0, 0, 1, (k == K_ADDU || k == K_SUBU) ? 1 : 0,
                                       src, aop, ext, 0, (k == K_LW) ? 1 : 0, 1));
            end
        endcase
    endtask

    task automatic check_output(input logic [18:0] got, input logic [18:0] want, input string tag);
        checks++;
        assert (got === want)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%05h expected=%05h", tag, got, want);
        end
    endtask

    // Entry point: #1 after the posedge that starts a FETCH cycle; exits at the same point of the next one
    task automatic apply_stimulus(input logic [5:0] o, input logic [5:0] f, input logic z,
                                  input bit trap, input string tag);
        op = o;
        func = f;
        zero = z;
        build_expect(kind_of(o, f), z, trap);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            check_output(trap ? obs1 : obs0, exp_q[i], $sformatf("%s cyc%0d", tag, i));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic random_instr(input bit allow_illegal, output logic [5:0] o, output logic [5:0] f);
        int k;
        k = allow_illegal ? $urandom_range(0, 10) : $urandom_range(0, 9);
        if (k < 10) begin
            o = op_tab[k];
            f = (o == 6'h00) ? func_tab[k] : 6'($urandom);
        end else begin
            do begin
                o = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom);
                f = 6'($urandom);
            end while (kind_of(o, f) != K_ILL);
        end
    endtask

    initial begin
        logic [5:0] ro, rf;
        $display("[TB] start");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output(obs0, 19'd0, "reset_nop");
        check_output(obs1, 19'd0, "reset_trap");
        @(posedge clk);
        #1 reset0 = 1'b0;

        apply_stimulus(6'h0D, 6'h00, 1'b0, 1'b0, "ori");
        apply_stimulus(6'h23, 6'h00, 1'b0, 1'b0, "lw");
        apply_stimulus(6'h2B, 6'h00, 1'b0, 1'b0, "sw");
        apply_stimulus(6'h04, 6'h00, 1'b1, 1'b0, "beq_taken");
        apply_stimulus(6'h04, 6'h00, 1'b0, 1'b0, "beq_not_taken");
        apply_stimulus(6'h03, 6'h00, 1'b0, 1'b0, "jal");
        apply_stimulus(6'h02, 6'h00, 1'b0, 1'b0, "j");
        apply_stimulus(6'h00, 6'h08, 1'b0, 1'b0, "jr");
        apply_stimulus(6'h00, 6'h21, 1'b0, 1'b0, "addu");
        apply_stimulus(6'h00, 6'h23, 1'b1, 1'b0, "subu");
        apply_stimulus(6'h0F, 6'h00, 1'b0, 1'b0, "lui");
        apply_stimulus(6'h3F, 6'h00, 1'b0, 1'b0, "illegal_op_nop");
        apply_stimulus(6'h00, 6'h20, 1'b0, 1'b0, "illegal_func_nop");

        for (int n = 0; n < 80; n++) begin
            random_instr(1'b1, ro, rf);
            apply_stimulus(ro, rf, 1'($urandom), 1'b0, $sformatf("rand%0d op%02h f%02h", n, ro, rf));
        end

        // Reset arriving during the MEM cycle of a store must suppress the write
        op = 6'h2B;
        func = 6'h00;
        repeat (3) @(posedge clk);
        #1 reset0 = 1'b1;
        @(negedge clk);
        check_output({18'd0, mem_wr0}, 19'd0, "sw_reset_mem_wr");
        check_output(obs0, 19'd0, "sw_reset_outputs");
        @(posedge clk);
        #1 reset0 = 1'b0;
        apply_stimulus(6'h23, 6'h00, 1'b0, 1'b0, "lw_after_reset");

        reset1 = 1'b0;
        apply_stimulus(6'h0D, 6'h00, 1'b0, 1'b1, "trap_ori");
        for (int n = 0; n < 15; n++) begin
            random_instr(1'b0, ro, rf);
            apply_stimulus(ro, rf, 1'($urandom), 1'b1, $sformatf("trap_rand%0d op%02h", n, ro));
        end
        apply_stimulus(6'h3F, 6'h00, 1'b0, 1'b1, "trap_halt");
        reset1 = 1'b1;
        @(negedge clk);
        check_output(obs1, 19'd0, "halt_reset_outputs");
        @(posedge clk);
        #1 reset1 = 1'b0;
        apply_stimulus(6'h00, 6'h21, 1'b0, 1'b1, "trap_recover_addu");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameter TRAP_ON_ILLEGAL, default 0: 1 = unrecognised opcode/funct enters HALT; 0 = treated as NOP.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op  input  6  IR[31:26], held stable by the datapath IR after FETCH.
REQ-005 func  input  6  IR[5:0].
REQ-006 zero  input  1  ALU equality flag from datapath, valid in EXE.
REQ-007 pc_wr  output  1  PC write enable.
REQ-008 npc_sel  output  2  0=PC+4, 1=branch target, 2=j/jal target, 3=GPR[rs].
REQ-009 ir_wr  output  1  IR load enable.
REQ-010 reg_wr  output  1  GRF write enable.
REQ-011 reg_dst  output  2  0=rt, 1=rd, 2=$31.
REQ-012 alu_src  output  1  0=GPR[rt], 1=extended immediate.
REQ-013 alu_op  output  3  0=add, 1=sub, 2=or, 3=lui (imm<<16).
REQ-014 ext_op  output  1  1=sign extend, 0=zero extend.
REQ-015 mem_wr  output  1  DM write enable.
REQ-016 mem_to_reg  output  2  0=ALU result, 1=DM data, 2=PC+4.
REQ-017 state  output  3  current state encoding.
REQ-018 instr_done  output  1  one-cycle pulse in the last cycle of each instruction.

Function
REQ-019 States SHALL be FETCH=0, DECODE=1, EXE=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL go to FETCH next cycle with all strobes 0.
REQ-020 Supported set: addu, subu, jr (op 0, func 0x21/0x23/0x08), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02, jal 0x03.
REQ-021 FETCH: ir_wr=1, pc_wr=1, npc_sel=0; next DECODE.
REQ-022 DECODE: j -> pc_wr=1, npc_sel=2, next FETCH; jal -> additionally reg_wr=1, reg_dst=2, mem_to_reg=2; jr -> pc_wr=1, npc_sel=3, next FETCH; all others -> EXE.
REQ-023 EXE: addu/subu alu_src=0, alu_op 0/1; ori alu_src=1, ext_op=0, alu_op=2; lui alu_op=3; lw/sw alu_src=1, ext_op=1, alu_op=0; beq alu_op=1, pc_wr=zero, npc_sel=1, next FETCH.
REQ-024 EXE next: lw/sw -> MEM; addu/subu/ori/lui -> WB.
REQ-025 MEM: sw -> mem_wr=1, next FETCH; lw -> next WB.
REQ-026 WB: reg_wr=1; reg_dst=1 for R-type, 0 otherwise; mem_to_reg=1 for lw, 0 otherwise; next FETCH.
REQ-027 Latency in cycles (FETCH..last): j/jal/jr 2, beq 3, R-type/ori/lui/sw 4, lw 5.
REQ-028 ALU/mux selects SHALL be held through the state following EXE (MEM/WB) so datapath registers see stable inputs.
REQ-029 Illegal instruction: TRAP_ON_ILLEGAL=0 -> DECODE to FETCH, no writes, instr_done=1; =1 -> HALT, all strobes 0, remain until reset.
REQ-030 instr_done SHALL equal 1 exactly in the cycle whose next state is FETCH (from non-FETCH), never in HALT.
REQ-031 Every write strobe not explicitly asserted in a state SHALL be 0; op/func are sampled only in DECODE..WB.

Reset
REQ-032 While reset=1 at a rising edge, state SHALL become FETCH; all outputs SHALL be 0 in any cycle where reset=1 (combinational qualification), including mid-instruction and in HALT.
REQ-033 First cycle after reset deasserts: state=0, ir_wr=1, pc_wr=1.

Verification
REQ-034 Reset then op=0x0D: states 0,1,2,4,0; reg_wr=1 only in WB with reg_dst=0, ext_op=0, alu_op=2; instr_done once.
REQ-035 lw (0x23): states 0,1,2,3,4; mem_to_reg=1 in WB; sw (0x2B): 0,1,2,3 with mem_wr=1 only in MEM.
REQ-036 beq zero=1 -> pc_wr=1, npc_sel=1 in EXE; zero=0 -> pc_wr=0; both return to FETCH after 3 cycles.
REQ-037 jal: DECODE pc_wr=1, npc_sel=2, reg_wr=1, reg_dst=2, mem_to_reg=2; next FETCH.
REQ-038 op=0x3F with TRAP_ON_ILLEGAL=1 -> HALT, outputs 0 for 10 cycles; reset -> FETCH. With 0 -> FETCH after DECODE, no writes.
REQ-039 Assert reset during MEM of sw -> mem_wr=0 that cycle, state=0 next cycle.
